bank_req_fifo: RTL
==================

# bank_req_fifo

Parametrised request FIFO for the bank scheduler front end: one instance buffers the read/write requests destined for one DRAM bank. It replaces the fixed-function per-bank queue with arbitrary depth, an exact occupancy count, a programmable occupancy threshold, a synchronous flush, and correct tracking of the row address of the most recently pushed request. The bank scheduler uses these signals for row-hit-first and fullness-aware arbitration.

## Interface
- DATA_WIDTH, 32, request word width
- DATA_DEPTH, 4, number of entries; any integer >= 2, not restricted to powers of two
- RA_POS, 20, LSB position of the row-address field inside a request word
- RA_BITS, 10, row-address field width; RA_POS+RA_BITS <= DATA_WIDTH
- MID_THRESH, DATA_DEPTH/2, occupancy at or above which mid_o asserts; range 1..DATA_DEPTH

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush, empties the FIFO
- data_i  in  DATA_WIDTH  push data
- valid_i  in  1  push request
- grant_o  out  1  push accepted when high (FIFO not full)
- data_o  out  DATA_WIDTH  head entry
- valid_o  out  1  head valid (FIFO not empty)
- grant_i  in  1  pop; ignored when valid_o=0
- count_o  out  $clog2(DATA_DEPTH+1)  current occupancy
- mid_o  out  1  count_o >= MID_THRESH
- last_row_o  out  RA_BITS  row field of the most recently accepted push
- last_row_valid_o  out  1  last_row_o is meaningful
- row_hit_o  out  1  incoming request hits last_row_o (see Configuration)

## Operation
- State machine with states EMPTY, MIDDLE and FULL. Transitions are driven by the push/pop events and by count.
  - EMPTY to MIDDLE on push.
  - MIDDLE to EMPTY on a pop-only cycle when count=1.
  - MIDDLE to FULL on a push-only cycle when count=DATA_DEPTH-1.
  - FULL to MIDDLE on pop.
  - Any illegal encoding returns to EMPTY.
- A push occurs when valid_i and grant_o are both high. The word is written at the write pointer.
- A pop occurs when grant_i and valid_o are both high. The read pointer advances.
- Both pointers wrap from DATA_DEPTH-1 to 0 by explicit compare, not by natural overflow.
- Push and pop in the same cycle, in MIDDLE: both pointers advance and count is unchanged.
- In FULL, grant_o is 0, so a push is not accepted even when a pop occurs in the same cycle.
- In EMPTY, grant_i has no effect.
- count_o arithmetic per cycle: +1 on push only, -1 on pop only, 0 otherwise. It never leaves the range 0..DATA_DEPTH.
- last_row_o captures data_i[RA_POS +: RA_BITS] on every accepted push. It holds its value through subsequent pops.
- last_row_valid_o sets on the first push after reset or flush.
- flush_i has priority over push and pop in the same cycle. On flush:
  - state goes to EMPTY, pointers go to 0 and count goes to 0;
  - last_row_valid_o clears;
  - storage contents are not cleared.

## Timing
- Reset values:
  - grant_o=1, valid_o=0, count_o=0, mid_o=0;
  - last_row_o=0, last_row_valid_o=0, row_hit_o=0;
  - data_o=0, with storage cleared on reset.
- There is no fall-through. A word pushed in cycle N is on data_o with valid_o=1 in cycle N+1.
- grant_o, valid_o, count_o and mid_o derive only from registered state, with no combinational path from inputs.
- data_o is a combinational read of the head entry.
- row_hit_o is combinational from valid_i, data_i and the registered last_row_o.
- Asserting rst_n low mid-operation drops every output to its reset value immediately, without waiting for a clock edge.

## Configuration
- Macro: BANK_FIFO_ROW_HIT_EN.
- When defined:
  - row_hit_o = valid_i & last_row_valid_o & (data_i[RA_POS +: RA_BITS] == last_row_o);
  - a pushed request's row is compared against the previous push, independent of pops.
- When undefined:
  - row_hit_o is tied to 0 and the comparator is not built;
  - last_row_o and last_row_valid_o remain functional.

## Structure
- Shared package bank_sched_pkg holds:
  - fifo_state_e, a 2-bit enum {EMPTY, MIDDLE, FULL};
  - function ptr_inc(ptr, depth), which returns the incremented pointer with wrap-around.
- One sub-module, bank_fifo_ptr_ctrl, holds the state machine, both pointers and count. It outputs the push enable, pop enable and pointers.
- The top level holds the storage array, the row-tracking register and the row-hit compare.

## Test plan
- Reset, then push 4 words 0xA0..0xA3 (DATA_DEPTH=4) -> grant_o=0 after the 4th push, count_o=4, mid_o=1, data_o=0xA0.
- With the FIFO full, assert push and pop together -> pop only; count_o=3, data_o=0xA1, pushed word dropped.
- DATA_DEPTH=5: perform 12 alternating push/pop cycles -> pointers wrap through 4 to 0, data order preserved, count_o stays at or below 1.
- Push a row 0x155 word, then offer another row 0x155 word with the macro defined -> row_hit_o=1. Then offer row 0x156 -> row_hit_o=0.
- Push 3 words, then assert flush_i together with valid_i -> next cycle count_o=0, valid_o=0, last_row_valid_o=0, and the push is ignored.
- Push 2 words, then drop rst_n between clock edges -> valid_o=0, count_o=0 and grant_o=1 without any clock edge.

Source files
------------

// File: rtl/bank_sched_pkg.sv
// Shared types and helpers for the bank scheduler front end: FIFO state encoding
// and the wrap-around pointer increment used by the per-bank request FIFOs.
package bank_sched_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    MIDDLE = 2'd1,
    FULL   = 2'd2
  } fifo_state_e;

  // Wrap by explicit compare so non-power-of-two depths index correctly.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    int unsigned nxt_s;
    if (ptr == depth - 32'd1) begin
      nxt_s = 32'd0;
    end else begin
      nxt_s = ptr + 32'd1;
    end
    return nxt_s;
  endfunction

endpackage

// File: rtl/bank_fifo_ptr_ctrl.sv
// Control path of bank_req_fifo: EMPTY/MIDDLE/FULL state machine, read/write
// pointers and exact occupancy count, with synchronous flush taking priority.
module bank_fifo_ptr_ctrl
  import bank_sched_pkg::*;
#(
  parameter int DATA_DEPTH = 4,
  parameter int PTR_W      = $clog2(DATA_DEPTH),
  parameter int CNT_W      = $clog2(DATA_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic             grant_i,
  output logic             push_en_o,
  output logic             pop_en_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             grant_o,
  output logic             valid_o
);

  fifo_state_e      state_r, state_n_s;
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s, pop_s;

  assign grant_o   = (state_r != FULL);
  assign valid_o   = (state_r != EMPTY);
  assign push_s    = valid_i & grant_o & ~flush_i;
  assign pop_s     = grant_i & valid_o & ~flush_i;
  assign push_en_o = push_s;
  assign pop_en_o  = pop_s;
  assign wr_ptr_o  = wr_ptr_r;
  assign rd_ptr_o  = rd_ptr_r;
  assign count_o   = count_r;

  // Next-state decode from push/pop events and current occupancy.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      EMPTY: begin
        if (push_s) begin
          state_n_s = MIDDLE;
        end else begin
          state_n_s = EMPTY;
        end
      end
      MIDDLE: begin
        if (pop_s && !push_s && (count_r == CNT_W'(1))) begin
          state_n_s = EMPTY;
        end else if (push_s && !pop_s && (count_r == CNT_W'(DATA_DEPTH - 1))) begin
          state_n_s = FULL;
        end else begin
          state_n_s = MIDDLE;
        end
      end
      FULL: begin
        if (pop_s) begin
          state_n_s = MIDDLE;
        end else begin
          state_n_s = FULL;
        end
      end
      default: state_n_s = EMPTY;
    endcase
  end

  // State, pointer and count registers; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= EMPTY;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      state_r  <= EMPTY;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_n_s;
      if (push_s) begin
        wr_ptr_r <= PTR_W'(ptr_inc(32'(wr_ptr_r), 32'(DATA_DEPTH)));
      end
      if (pop_s) begin
        rd_ptr_r <= PTR_W'(ptr_inc(32'(rd_ptr_r), 32'(DATA_DEPTH)));
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bank_req_fifo.sv
// Per-bank request FIFO: storage, last-pushed row tracking and optional row-hit
// compare (enabled by defining BANK_FIFO_ROW_HIT_EN).
module bank_req_fifo
  import bank_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 4,
  parameter int RA_POS     = 20,
  parameter int RA_BITS    = 10,
  parameter int MID_THRESH = DATA_DEPTH / 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic                           valid_i,
  output logic                           grant_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           valid_o,
  input  logic                           grant_i,
  output logic [$clog2(DATA_DEPTH+1)-1:0] count_o,
  output logic                           mid_o,
  output logic [RA_BITS-1:0]             last_row_o,
  output logic                           last_row_valid_o,
  output logic                           row_hit_o
);

  localparam int PTR_W = $clog2(DATA_DEPTH);
  localparam int CNT_W = $clog2(DATA_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_r [DATA_DEPTH];
  logic                  push_en_s, pop_en_s;
  logic [PTR_W-1:0]      wr_ptr_s, rd_ptr_s;
  logic [CNT_W-1:0]      count_s;
  logic [RA_BITS-1:0]    last_row_r;
  logic                  last_row_valid_r;

  bank_fifo_ptr_ctrl #(
    .DATA_DEPTH (DATA_DEPTH),
    .PTR_W      (PTR_W),
    .CNT_W      (CNT_W)
  ) u_ptr_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .grant_i   (grant_i),
    .push_en_o (push_en_s),
    .pop_en_o  (pop_en_s),
    .wr_ptr_o  (wr_ptr_s),
    .rd_ptr_o  (rd_ptr_s),
    .count_o   (count_s),
    .grant_o   (grant_o),
    .valid_o   (valid_o)
  );

  assign count_o = count_s;
  assign mid_o   = (count_s >= CNT_W'(MID_THRESH));
  assign data_o  = mem_r[rd_ptr_s];

  // Storage array; cleared on reset only, flush leaves contents intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_en_s) begin
      mem_r[wr_ptr_s] <= data_i;
    end else begin
      mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
    end
  end

  // Row of the most recent accepted push; pops never disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_row_r       <= {RA_BITS{1'b0}};
      last_row_valid_r <= 1'b0;
    end else if (flush_i) begin
      last_row_r       <= last_row_r;
      last_row_valid_r <= 1'b0;
    end else if (push_en_s) begin
      last_row_r       <= data_i[RA_POS +: RA_BITS];
      last_row_valid_r <= 1'b1;
    end else begin
      last_row_r       <= last_row_r;
      last_row_valid_r <= last_row_valid_r;
    end
  end

  assign last_row_o       = last_row_r;
  assign last_row_valid_o = last_row_valid_r;

`ifdef BANK_FIFO_ROW_HIT_EN
  assign row_hit_o = valid_i & last_row_valid_r & (data_i[RA_POS +: RA_BITS] == last_row_r);
`else
  assign row_hit_o = 1'b0;
`endif

endmodule
